// File: rtl/pisei_pkg.sv
// rtl/pisei_pkg.sv - shared types and constants for the PISEI scan sequencer
package pisei_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int IDX_W    = 4;
    localparam int NUM_COMB = 16;

    // Settle down-counter must hold SETTLE_CYCLES + SYNC_STAGES - 1, max 255 + 3 - 1
    localparam int CNT_W = 9;

    // Golden result when the core decodes correctly (out = 1 only when decoder == A)
    localparam logic [NUM_COMB-1:0] EXPECTED_DEFAULT = 16'h8421;

endpackage

// File: rtl/pisei_sync.sv
// rtl/pisei_sync.sv - N-stage reset-to-zero synchronizer for an asynchronous input
module pisei_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pisei_scan_sequencer.sv
// rtl/pisei_scan_sequencer.sv - steps decoder/mux codes through 16 combinations and packs sampled outputs; optional self-check via PISEI_SCAN_SELFCHECK_EN
module pisei_scan_sequencer
    import pisei_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
`ifdef PISEI_SCAN_SELFCHECK_EN
    ,
    parameter logic [NUM_COMB-1:0] EXPECTED = EXPECTED_DEFAULT
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mux_out,
    output logic [1:0]          control_decoder,
    output logic [1:0]          A,
    output logic                busy,
    output logic [NUM_COMB-1:0] result,
    output logic                result_valid,
    input  logic                result_ready
`ifdef PISEI_SCAN_SELFCHECK_EN
    ,
    output logic                pass
`endif
);

    // Cycles spent in DRIVE per combination, loaded as count-to-zero
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_COMB - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_COMB-1:0] result_q, result_d;
    logic                mux_sync;

`ifdef PISEI_SCAN_SELFCHECK_EN
    logic pass_q, pass_d;
`endif

    pisei_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (mux_out),
        .q_o (mux_sync)
    );

    // State, index, settle counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

`ifdef PISEI_SCAN_SELFCHECK_EN
    // Self-check verdict register
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q <= 1'b0;
        end else begin
            pass_q <= pass_d;
        end
    end
`endif

    // Next-state logic: IDLE -> (DRIVE -> SAMPLE) x16 -> DONE -> IDLE
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef PISEI_SCAN_SELFCHECK_EN
        pass_d   = pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d = '0;
                    idx_d    = '0;
                    cnt_d    = HOLD_LOAD;
                    state_d  = ST_DRIVE;
`ifdef PISEI_SCAN_SELFCHECK_EN
                    pass_d   = 1'b0;
`endif
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                result_d[idx_q] = mux_sync;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
`ifdef PISEI_SCAN_SELFCHECK_EN
                    pass_d  = (result_d == EXPECTED);
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                // Codes stay at the last combination until the result is taken
                if (result_ready) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign control_decoder = idx_q[3:2];
    assign A               = idx_q[1:0];
    assign busy            = (state_q != ST_IDLE);
    assign result          = result_q;
    assign result_valid    = (state_q == ST_DONE);
`ifdef PISEI_SCAN_SELFCHECK_EN
    assign pass            = pass_q;
`endif

endmodule

// File: tb/tb_pisei_scan_sequencer.sv
// tb/tb_pisei_scan_sequencer.sv - directed self-checking bench for pisei_scan_sequencer
module tb_pisei_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic        ready0, ready1;
    logic        force_one;
    logic        mux0, mux1;
    logic [1:0]  cd0, a0, cd1, a1;
    logic        busy0, busy1;
    logic [15:0] res0, res1;
    logic        valid0, valid1;
`ifdef PISEI_SCAN_SELFCHECK_EN
    logic        pass0, pass1;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    logic stable;

    always #5 clk = ~clk;

    // Core model: out is high when decoder code equals mux select
    assign mux0 = force_one ? 1'b1 : (cd0 == a0);
    assign mux1 = (cd1 == a1);

    pisei_scan_sequencer dut0 (
        .clk             (clk),
        .rst             (rst),
        .start           (start0),
        .mux_out         (mux0),
        .control_decoder (cd0),
        .A               (a0),
        .busy            (busy0),
        .result          (res0),
        .result_valid    (valid0),
        .result_ready    (ready0)
`ifdef PISEI_SCAN_SELFCHECK_EN
        ,
        .pass            (pass0)
`endif
    );

    pisei_scan_sequencer #(
        .SETTLE_CYCLES (1)
    ) dut1 (
        .clk             (clk),
        .rst             (rst),
        .start           (start1),
        .mux_out         (mux1),
        .control_decoder (cd1),
        .A               (a1),
        .busy            (busy1),
        .result          (res1),
        .result_valid    (valid1),
        .result_ready    (ready1)
`ifdef PISEI_SCAN_SELFCHECK_EN
        ,
        .pass            (pass1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start0 in cycle 0 and returns the cycle in which result_valid rises (-1 on timeout);
    // mid_start injects a second start pulse in that cycle (0 = none)
    task automatic scan0(input int mid_start, output int vcyc);
        vcyc   = -1;
        start0 = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            tick();
            start0 = (c == mid_start);
            if (valid0) begin
                vcyc = c;
                break;
            end
        end
        start0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1; force_one = 1'b0;
        repeat (3) tick();
        check("rst_cd",    32'(cd0),    32'd0);
        check("rst_a",     32'(a0),     32'd0);
        check("rst_busy",  32'(busy0),  32'd0);
        check("rst_res",   32'(res0),   32'd0);
        check("rst_valid", 32'(valid0), 32'd0);
`ifdef PISEI_SCAN_SELFCHECK_EN
        check("rst_pass",  32'(pass0),  32'd0);
`endif
        rst = 1'b0;
        tick();

        // Nominal scan with ready held high
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("busy_c1",  32'(busy0),      32'd1);
        check("codes_c1", 32'({cd0, a0}),  32'd0);
        cyc = 1;
        while (!valid0 && cyc < 400) begin
            tick();
            cyc++;
        end
        check("valid_cycle", 32'(cyc),  32'd113);
        check("result_gold", 32'(res0), 32'h8421);
`ifdef PISEI_SCAN_SELFCHECK_EN
        check("pass_gold",   32'(pass0), 32'd1);
`endif
        tick();
        check("xfer_valid", 32'(valid0), 32'd0);
        check("xfer_busy",  32'(busy0),  32'd0);
        check("xfer_res",   32'(res0),   32'h8421);
        tick();

        // mux_out stuck high, ready held low after valid
        force_one = 1'b1;
        ready0    = 1'b0;
        scan0(0, cyc);
        check("ones_cycle",  32'(cyc),  32'd113);
        check("ones_result", 32'(res0), 32'hFFFF);
`ifdef PISEI_SCAN_SELFCHECK_EN
        check("ones_pass",   32'(pass0), 32'd0);
`endif
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res0 !== 16'hFFFF || valid0 !== 1'b1 || {cd0, a0} !== 4'hF || busy0 !== 1'b1)
                stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        // Transfer with start in the same cycle: start must be ignored
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("hs_valid", 32'(valid0), 32'd0);
        check("hs_busy",  32'(busy0),  32'd0);
        check("hs_codes", 32'({cd0, a0}), 32'd0);
        tick();
        check("hs_nostart", 32'(busy0), 32'd0);
        force_one = 1'b0;

        // Extra start in cycle 50 has no effect
        scan0(50, cyc);
        check("midstart_cycle",  32'(cyc),  32'd113);
        check("midstart_result", 32'(res0), 32'h8421);
        tick();
        tick();

        // Reset during a scan at cycle 60
        start0 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            start0 = 1'b0;
        end
        check("pre_rst_busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_cd",    32'(cd0),    32'd0);
        check("mrst_a",     32'(a0),     32'd0);
        check("mrst_busy",  32'(busy0),  32'd0);
        check("mrst_res",   32'(res0),   32'd0);
        check("mrst_valid", 32'(valid0), 32'd0);
        tick();
        check("mrst_idle", 32'(busy0), 32'd0);
        scan0(0, cyc);
        check("post_rst_cycle",  32'(cyc),  32'd113);
        check("post_rst_result", 32'(res0), 32'h8421);
`ifdef PISEI_SCAN_SELFCHECK_EN
        check("post_rst_pass",   32'(pass0), 32'd1);
`endif
        tick();

        // Sweep with SETTLE_CYCLES = 1: period 4, codes k live in cycles 4k+1..4k+4
        start1 = 1'b1;
        for (int c = 1; c <= 65; c++) begin
            tick();
            start1 = 1'b0;
            if (c <= 64)
                check("sweep_code", 32'({cd1, a1}), 32'((c - 1) / 4));
            if (c == 64 || c == 65)
                check("sweep_valid", 32'(valid1), 32'(c == 65));
        end
        check("sweep_result", 32'(res1), 32'h8421);
        tick();
        check("sweep_busy", 32'(busy1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
